regfile_dump_reader: RTL

- Read-side client for the 32x32 register file.
- On a start command, walks the file's asynchronous read port over an index range and streams each word out on a valid/ready interface, tagged with its index.
- Used for debug dump and context save; sits between the register file read port and the debug/DMA stream sink.
- Never drives the register file's write port.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_dump_reader_stream_out_reg.sv | 33 +++
 rtl/regfile_dump_reader.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file geometry and dump FSM state encoding.
package regfile_pkg;
  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT = 32;
  typedef enum logic [1:0] {DUMP_IDLE, DUMP_RUN, DUMP_CSUM, DUMP_DRAIN} dump_state_t;
endpackage

// File: rtl/regfile_dump_reader_stream_out_reg.sv
// stream_out_reg: single-entry valid/ready output register carrying data, index and last.
module stream_out_reg #(
  parameter int DATA_W = 32,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  idx,
  input  logic              last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last
);
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_idx <= '0;
      m_last <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data <= data;
      m_idx <= idx;
      m_last <= last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams a wrapping index range of the register file out on valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat after the data beats.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_ridx,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_idx,
  output logic              m_last
);
  dump_state_t state;
  logic [ADDR_W-1:0] cur_idx, end_idx, beat_idx;
  logic [DATA_W-1:0] beat_data;
  logic can_load, run_load, csum_load, final_word, beat_last;
  assign can_load = !m_valid || m_ready;
  assign run_load = state == DUMP_RUN && can_load;
  assign final_word = cur_idx == end_idx;
  // cur_idx is itself a register, so the read address stays stable for a whole cycle
  assign rf_ridx = cur_idx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam dump_state_t AFTER_RUN = DUMP_CSUM;
  logic [DATA_W-1:0] acc;
  always_ff @(posedge clk) begin
    if (reset || (state == DUMP_IDLE && start)) acc <= '0;
    else if (run_load) acc <= acc ^ rf_rdata;
  end
  assign csum_load = state == DUMP_CSUM && can_load;
  assign beat_data = csum_load ? acc : rf_rdata;
  assign beat_idx = csum_load ? '0 : cur_idx;
  assign beat_last = csum_load;
`else
  localparam dump_state_t AFTER_RUN = DUMP_DRAIN;
  assign csum_load = 1'b0;
  assign beat_data = rf_rdata;
  assign beat_idx = cur_idx;
  assign beat_last = final_word;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DUMP_IDLE;
      cur_idx <= '0;
      end_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DUMP_IDLE: if (start) begin
          state <= DUMP_RUN;
          cur_idx <= first_idx;
          end_idx <= last_idx;
          busy <= 1'b1;
        end
        DUMP_RUN: if (can_load) begin
          cur_idx <= cur_idx + ADDR_W'(1);
          if (final_word) state <= AFTER_RUN;
        end
        DUMP_CSUM: if (can_load) state <= DUMP_DRAIN;
        DUMP_DRAIN: if (m_valid && m_ready && m_last) begin
          state <= DUMP_IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  end
  stream_out_reg #(.DATA_W(DATA_W), .IDX_W(ADDR_W)) u_out (
    .clk(clk),
    .reset(reset),
    .load(run_load || csum_load),
    .data(beat_data),
    .idx(beat_idx),
    .last(beat_last),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_idx(m_idx),
    .m_last(m_last)
  );
endmodule
